hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-table hazard control unit of the 5-stage MIPS pipeline.
- Replaces the hard-coded cal/load Tnew decoding with a per-stage scoreboard of (dest, Tnew) that shifts and ages each cycle.
- Adds a multi-cycle MDU busy counter for HI/LO hazards.
- Produces forwarding selects for ID-stage operands.
- Sits in the controller beside the ID-stage decoder and drives the pipeline stall/bubble controls.

Parameters:
- NSTAGE, 3, number of tracked stages after ID (slot 0 = EX, slot 1 = MEM, slot 2 = WB, ...).
- TW, 2, width of the Tuse and Tnew fields.
- MD_MUL_LAT, 5, cycles for mult/multu.
- MD_DIV_LAT, 10, cycles for div/divu.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_stall_MEM  in  1  memory-side stall; freezes the whole pipeline
- id_valid  in  1  ID holds a real instruction
- A1_ID  in  5  rs index
- A2_ID  in  5  rt index
- Tuse_rs  in  TW  cycles until rs is needed
- Tuse_rt  in  TW  cycles until rt is needed
- A3_ID  in  5  destination register
- wen_ID  in  1  instruction writes A3_ID
- Tnew_ID  in  TW  Tnew value the instruction will have on entering EX (cal=1, load=2)
- md_use_ID  in  1  instruction reads HI/LO or starts the MDU
- md_start_ID  in  1  instruction starts the MDU
- md_div_ID  in  1  1 = divide latency, 0 = multiply latency
- stall  out  1  freeze PC/IF/ID
- bubble_EX  out  1  clear ID/EX this cycle
- fwd_rs_sel  out  $clog2(NSTAGE+1)  0 = register file, k+1 = slot k
- fwd_rt_sel  out  $clog2(NSTAGE+1)  same encoding, for rt
- md_busy  out  1  MDU counter nonzero

Behaviour:
- Reset (asynchronous, rst_n low): all slots invalid, md_cnt = 0.
  - While reset is asserted: stall = mem_stall_MEM, bubble_EX = 0, fwd_*_sel = 0, md_busy = 0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Slot contents: valid, A3 (5 bits), tnew (TW bits). Entries are only created when wen_ID = 1 and A3_ID != 0.
- Match rule (rs; rt identical with A2/Tuse_rt):
  - If id_valid and A1_ID != 0, take the lowest-index valid slot k with A3 == A1_ID (youngest writer wins).
  - stall_rs = (slot k tnew > Tuse_rs).
  - fwd_rs_sel = k+1 if slot k tnew == 0, else 0.
  - If there is no match, or id_valid = 0, then stall_rs = 0 and fwd_rs_sel = 0.
- MDU stall: stall_md = id_valid & md_use_ID & (md_cnt != 0).
- Output combination (combinational from state and inputs):
  - hz = stall_rs | stall_rt | stall_md.
  - stall = hz | mem_stall_MEM.
  - bubble_EX = hz & ~mem_stall_MEM.
- Slot update at the clock edge, mutually exclusive, in priority order:
  - mem_stall_MEM = 1: hold all slots unchanged, tnew not decremented. Freeze overrides hz.
  - hz = 1: slot 0 <= invalid (bubble); slot i <= slot i-1 with tnew decremented, saturating at 0.
  - Otherwise (advance): slot 0 <= {id_valid & wen_ID & (A3_ID != 0), A3_ID, Tnew_ID}; slot i <= slot i-1 with tnew saturating-decremented.
  - In both shifting cases, the entry leaving slot NSTAGE-1 is dropped.
- MDU counter, width $clog2(MD_DIV_LAT+1):
  - On advance with id_valid & md_start_ID: load MD_DIV_LAT if md_div_ID, else MD_MUL_LAT.
  - Otherwise, if md_cnt != 0: decrement every cycle, including during mem_stall_MEM (the MDU runs independently).
  - A start issued while busy never loads, because md_start implies md_use and is therefore stalled.
- md_busy = (md_cnt != 0), registered-state derived.
- Latency: a hazard resolves the cycle after the producing slot's tnew falls to ≤ Tuse. No added pipeline latency on the stall path.

Test Plan:
- add $3 (Tnew_ID=1) advances, then beq $3 (Tuse_rs=0) -> cycle 1: stall=1, bubble_EX=1; cycle 2: stall=0, fwd_rs_sel=2 (MEM).
- lw $5 (Tnew_ID=2) advances, then addu reading $5 (Tuse_rs=1) -> one stall cycle; next cycle stall=0 with lw in MEM at tnew=1 and fwd_rs_sel=0; one cycle later, with lw in WB, fwd_rs_sel=3 if sampled.
- Writer to $0, then a reader of $0 with Tuse=0 -> stall never asserts, fwd_*_sel=0; two back-to-back writers to $7, then a reader -> fwd selects slot 0 (youngest).
- mult advances, then mfhi -> md_busy=1, stall=1 for exactly 5 cycles (md_cnt 5..1); mfhi advances on the sixth cycle; divu gives 10 cycles.
- lw in slot 0 (tnew 2) with mem_stall_MEM=1 for 3 cycles -> slots frozen, tnew still 2, bubble_EX=0, stall=1; an MDU count of 4 drops to 1 over the same window.
- rst_n pulsed low while lw is pending and md_cnt=7 -> slots invalid and md_busy=0 immediately; stall follows mem_stall_MEM only.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoder-side operand/destination info in,
// stall/bubble/forwarding controls out.
interface hazard_scoreboard_if #(
    parameter int NSTAGE = 3,
    parameter int TW     = 2
);
    localparam int SW = $clog2(NSTAGE + 1);

    logic          mem_stall_MEM;
    logic          id_valid;
    logic [4:0]    A1_ID;
    logic [4:0]    A2_ID;
    logic [TW-1:0] Tuse_rs;
    logic [TW-1:0] Tuse_rt;
    logic [4:0]    A3_ID;
    logic          wen_ID;
    logic [TW-1:0] Tnew_ID;
    logic          md_use_ID;
    logic          md_start_ID;
    logic          md_div_ID;

    logic          stall;
    logic          bubble_EX;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;
    logic          md_busy;

    modport master (
        output mem_stall_MEM, id_valid, A1_ID, A2_ID, Tuse_rs, Tuse_rt,
               A3_ID, wen_ID, Tnew_ID, md_use_ID, md_start_ID, md_div_ID,
        input  stall, bubble_EX, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  mem_stall_MEM, id_valid, A1_ID, A2_ID, Tuse_rs, Tuse_rt,
               A3_ID, wen_ID, Tnew_ID, md_use_ID, md_start_ID, md_div_ID,
        output stall, bubble_EX, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-stage (dest, Tnew) scoreboard for the 5-stage pipeline. Each slot ages
// one stage per advancing cycle; the ID-stage operands are matched against the
// youngest writer to produce stall/bubble and forwarding selects. A down-counter
// tracks the multi-cycle MDU so HI/LO readers wait for completion.
module hazard_scoreboard #(
    parameter int NSTAGE     = 3,
    parameter int TW         = 2,
    parameter int MD_MUL_LAT = 5,
    parameter int MD_DIV_LAT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   sb
);
    localparam int SW = $clog2(NSTAGE + 1);
    localparam int CW = $clog2(MD_DIV_LAT + 1);

    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [4:0]        a3_q   [NSTAGE];
    logic [4:0]        a3_d   [NSTAGE];
    logic [TW-1:0]     tnew_q [NSTAGE];
    logic [TW-1:0]     tnew_d [NSTAGE];
    logic [CW-1:0]     md_cnt_q, md_cnt_d;

    logic          hit_rs, hit_rt;
    logic          stall_rs, stall_rt, stall_md, hz, advance;
    logic [SW-1:0] fwd_rs, fwd_rt;

    // Operand match: the lowest-index (youngest) valid writer decides stall/forward
    always_comb begin
        hit_rs   = 1'b0;
        hit_rt   = 1'b0;
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        fwd_rs   = '0;
        fwd_rt   = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (sb.id_valid && (sb.A1_ID != 5'd0) && !hit_rs &&
                vld_q[k] && (a3_q[k] == sb.A1_ID)) begin
                hit_rs   = 1'b1;
                stall_rs = (tnew_q[k] > sb.Tuse_rs);
                if (tnew_q[k] == '0) fwd_rs = SW'(k + 1);
            end
            if (sb.id_valid && (sb.A2_ID != 5'd0) && !hit_rt &&
                vld_q[k] && (a3_q[k] == sb.A2_ID)) begin
                hit_rt   = 1'b1;
                stall_rt = (tnew_q[k] > sb.Tuse_rt);
                if (tnew_q[k] == '0) fwd_rt = SW'(k + 1);
            end
        end
    end

    assign stall_md = sb.id_valid & sb.md_use_ID & (md_cnt_q != '0);
    assign hz       = stall_rs | stall_rt | stall_md;
    assign advance  = ~sb.mem_stall_MEM & ~hz;

    assign sb.stall      = hz | sb.mem_stall_MEM;
    assign sb.bubble_EX  = hz & ~sb.mem_stall_MEM;
    assign sb.fwd_rs_sel = fwd_rs;
    assign sb.fwd_rt_sel = fwd_rt;
    assign sb.md_busy    = (md_cnt_q != '0);

    // Slot shift: freeze on memory stall, inject a bubble on hazard, else take ID
    always_comb begin
        vld_d  = vld_q;
        a3_d   = a3_q;
        tnew_d = tnew_q;
        if (!sb.mem_stall_MEM) begin
            for (int i = NSTAGE - 1; i > 0; i--) begin
                vld_d[i]  = vld_q[i-1];
                a3_d[i]   = a3_q[i-1];
                tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - 1'b1;
            end
            if (hz) begin
                vld_d[0]  = 1'b0;
                a3_d[0]   = 5'd0;
                tnew_d[0] = '0;
            end else begin
                vld_d[0]  = sb.id_valid & sb.wen_ID & (sb.A3_ID != 5'd0);
                a3_d[0]   = sb.A3_ID;
                tnew_d[0] = sb.Tnew_ID;
            end
        end
    end

    // MDU counter: loads only when the starting instruction actually advances,
    // otherwise counts down regardless of pipeline freeze
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (advance && sb.id_valid && sb.md_start_ID) begin
            md_cnt_d = sb.md_div_ID ? CW'(MD_DIV_LAT) : CW'(MD_MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // State registers; reset discards every in-flight entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            md_cnt_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                a3_q[i]   <= 5'd0;
                tnew_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            a3_q     <= a3_d;
            tnew_q   <= tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios with
// hand-computed expectations, then randomized traffic against a queue model.
module tb_hazard_scoreboard;
    localparam int NSTAGE = 3;
    localparam int TW     = 2;
    localparam int MUL    = 5;
    localparam int DIV    = 10;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE), .TW(TW)) hif ();

    hazard_scoreboard #(.NSTAGE(NSTAGE), .TW(TW), .MD_MUL_LAT(MUL), .MD_DIV_LAT(DIV))
        dut (.clk(clk), .rst_n(rst_n), .sb(hif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] a3;
        int       tnew;
    } ent_t;

    ent_t pipe[$];
    int   edge_n   = 0;
    int   md_until = 0;
    int   ntests   = 0;
    int   nfail    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.a3 = 0; e.tnew = 0;
        pipe.delete();
        for (int i = 0; i < NSTAGE; i++) pipe.push_back(e);
        md_until = edge_n;
    endtask

    function automatic void match(input bit [4:0] a, input int tuse, output bit st, output int sel);
        st = 0; sel = 0;
        if (!hif.id_valid || a == 0) return;
        for (int k = 0; k < pipe.size(); k++) begin
            if (pipe[k].v && pipe[k].a3 == a) begin
                st  = pipe[k].tnew > tuse;
                sel = (pipe[k].tnew == 0) ? k + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic void expect_out(output bit st, output bit bb, output int frs,
                                       output int frt, output bit busy, output bit hzo);
        bit srs, srt, smd;
        match(hif.A1_ID, int'(hif.Tuse_rs), srs, frs);
        match(hif.A2_ID, int'(hif.Tuse_rt), srt, frt);
        busy = edge_n < md_until;
        smd  = hif.id_valid && hif.md_use_ID && busy;
        hzo  = srs | srt | smd;
        st   = hzo | hif.mem_stall_MEM;
        bb   = hzo & !hif.mem_stall_MEM;
    endfunction

    task automatic check_model();
        bit st, bb, busy, hzo;
        int frs, frt;
        expect_out(st, bb, frs, frt, busy, hzo);
        chk("m_stall",   hif.stall,      st);
        chk("m_bubble",  hif.bubble_EX,  bb);
        chk("m_fwd_rs",  hif.fwd_rs_sel, frs);
        chk("m_fwd_rt",  hif.fwd_rt_sel, frt);
        chk("m_md_busy", hif.md_busy,    busy);
    endtask

    task automatic model_edge();
        bit st, bb, busy, hzo, adv;
        int frs, frt;
        ent_t ne;
        expect_out(st, bb, frs, frt, busy, hzo);
        adv = !hif.mem_stall_MEM && !hzo;
        edge_n++;
        if (!hif.mem_stall_MEM) begin
            for (int k = 0; k < pipe.size(); k++)
                if (pipe[k].tnew > 0) pipe[k].tnew--;
            ne.v    = adv && hif.id_valid && hif.wen_ID && hif.A3_ID != 0;
            ne.a3   = hif.A3_ID;
            ne.tnew = int'(hif.Tnew_ID);
            pipe.push_front(ne);
            void'(pipe.pop_back());
        end
        if (adv && hif.id_valid && hif.md_start_ID)
            md_until = edge_n + (hif.md_div_ID ? DIV : MUL);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic settle();
        #4;
        check_model();
    endtask

    task automatic idle();
        hif.mem_stall_MEM = 0; hif.id_valid = 0;
        hif.A1_ID = 0; hif.A2_ID = 0; hif.Tuse_rs = 0; hif.Tuse_rt = 0;
        hif.A3_ID = 0; hif.wen_ID = 0; hif.Tnew_ID = 0;
        hif.md_use_ID = 0; hif.md_start_ID = 0; hif.md_div_ID = 0;
    endtask

    task automatic writer(input bit [4:0] a3, input int tnew);
        idle();
        hif.id_valid = 1; hif.wen_ID = 1; hif.A3_ID = a3; hif.Tnew_ID = TW'(tnew);
    endtask

    task automatic md_op(input bit start, input bit div);
        idle();
        hif.id_valid = 1; hif.md_use_ID = 1; hif.md_start_ID = start; hif.md_div_ID = div;
    endtask

    task automatic rand_inputs();
        hif.id_valid      = ($urandom_range(7, 0) != 0);
        hif.A1_ID         = 5'($urandom_range(3, 0));
        hif.A2_ID         = 5'($urandom_range(3, 0));
        hif.A3_ID         = 5'($urandom_range(3, 0));
        hif.wen_ID        = ($urandom_range(3, 0) != 0);
        hif.Tuse_rs       = TW'($urandom_range(2, 0));
        hif.Tuse_rt       = TW'($urandom_range(2, 0));
        hif.Tnew_ID       = TW'($urandom_range(3, 0));
        hif.md_start_ID   = ($urandom_range(15, 0) == 0);
        hif.md_use_ID     = hif.md_start_ID | ($urandom_range(3, 0) == 0);
        hif.md_div_ID     = $urandom_range(1, 0);
        hif.mem_stall_MEM = ($urandom_range(7, 0) == 0);
    endtask

    int n;

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #2;
        chk("rst_stall",   hif.stall, 0);
        chk("rst_bubble",  hif.bubble_EX, 0);
        chk("rst_fwd_rs",  hif.fwd_rs_sel, 0);
        chk("rst_md_busy", hif.md_busy, 0);
        hif.mem_stall_MEM = 1;
        #1;
        chk("rst_stall_follows_mem", hif.stall, 1);
        hif.mem_stall_MEM = 0;
        @(negedge clk);
        rst_n = 1;
        tick();

        // add $3 then beq $3
        writer(3, 1); settle(); tick();
        idle(); hif.id_valid = 1; hif.A1_ID = 3; hif.Tuse_rs = 0;
        settle();
        chk("beq_stall", hif.stall, 1);
        chk("beq_bubble", hif.bubble_EX, 1);
        tick(); settle();
        chk("beq_stall2", hif.stall, 0);
        chk("beq_fwd_mem", hif.fwd_rs_sel, 2);
        tick();

        // lw $5 then addu reading $5
        writer(5, 2); settle(); tick();
        idle(); hif.id_valid = 1; hif.A1_ID = 5; hif.Tuse_rs = 1;
        settle();
        chk("lw_use_stall", hif.stall, 1);
        tick(); settle();
        chk("lw_use_stall2", hif.stall, 0);
        chk("lw_use_fwd0", hif.fwd_rs_sel, 0);
        tick();
        idle(); hif.id_valid = 1; hif.A1_ID = 5; hif.Tuse_rs = 0;
        settle();
        chk("lw_wb_stall", hif.stall, 0);
        chk("lw_wb_fwd", hif.fwd_rs_sel, 3);
        tick();

        // $0 never tracked; youngest writer wins
        writer(0, 2); settle(); tick();
        idle(); hif.id_valid = 1; settle();
        chk("r0_stall", hif.stall, 0);
        chk("r0_fwd_rs", hif.fwd_rs_sel, 0);
        chk("r0_fwd_rt", hif.fwd_rt_sel, 0);
        tick();
        writer(7, 0); settle(); tick();
        writer(7, 0); settle(); tick();
        idle(); hif.id_valid = 1; hif.A2_ID = 7; hif.Tuse_rt = 0;
        settle();
        chk("young_stall", hif.stall, 0);
        chk("young_fwd_rt", hif.fwd_rt_sel, 1);
        tick();

        // mult / divu then mfhi
        for (int d = 0; d < 2; d++) begin
            md_op(1, d[0]); settle(); tick();
            md_op(0, 0);
            n = 0;
            for (int i = 0; i < 20; i++) begin
                settle();
                if (i == 0) chk("md_busy_start", hif.md_busy, 1);
                if (!hif.stall) break;
                n++;
                tick();
            end
            chk(d ? "div_stall_cycles" : "mul_stall_cycles", n, d ? DIV : MUL);
            chk("md_busy_done", hif.md_busy, 0);
            tick();
        end

        // memory freeze holds slots while the MDU keeps counting
        md_op(1, 0); settle(); tick();
        writer(5, 2); settle(); tick();
        idle(); hif.mem_stall_MEM = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("frz_stall", hif.stall, 1);
            chk("frz_bubble", hif.bubble_EX, 0);
            tick();
        end
        idle(); hif.id_valid = 1; hif.A1_ID = 5; hif.Tuse_rs = 0;
        settle();
        chk("frz_md_busy", hif.md_busy, 1);
        chk("frz_tnew_kept", hif.bubble_EX, 1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin settle(); tick(); end

        // reset mid-operation
        md_op(1, 1); settle(); tick();
        idle(); settle(); tick();
        settle(); tick();
        writer(5, 2); settle(); tick();
        idle(); hif.id_valid = 1; hif.A1_ID = 5; hif.md_use_ID = 1;
        settle();
        chk("pre_rst_stall", hif.stall, 1);
        #1 rst_n = 0; model_reset();
        #1;
        chk("mid_rst_md_busy", hif.md_busy, 0);
        chk("mid_rst_stall", hif.stall, 0);
        chk("mid_rst_fwd", hif.fwd_rs_sel, 0);
        hif.mem_stall_MEM = 1;
        #1;
        chk("mid_rst_stall_mem", hif.stall, 1);
        chk("mid_rst_bubble", hif.bubble_EX, 0);
        idle();
        #1 rst_n = 1;
        tick();

        // randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            if ($urandom_range(99, 0) == 0) begin
                #1 rst_n = 0; model_reset();
                #3 check_model();
                #2 rst_n = 1;
            end else begin
                settle();
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
